// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns one 256-bit cache line read/writeback into a 4-beat x 64-bit memory burst.
// Optional CACHELINE_ADAPTOR_PERF_EN adds completed line read/write counters.
module cacheline_adaptor #(
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_offset = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [s_line-1:0]   line_i,
  output logic [s_line-1:0]   line_o,
  input  logic [31:0]         address_i,
  input  logic                read_i,
  input  logic                write_i,
  output logic                resp_o,
  input  logic [s_burst-1:0]  burst_i,
  output logic [s_burst-1:0]  burst_o,
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i
`ifdef CACHELINE_ADAPTOR_PERF_EN
  ,
  output logic [31:0]         rd_count_o,
  output logic [31:0]         wr_count_o
`endif
);
  localparam int num_beats = s_line / s_burst;
  localparam logic [1:0] last_beat = 2'(num_beats - 1);
  localparam logic [31:0] off_mask = (32'd1 << s_offset) - 32'd1;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state, state_n;
  logic [1:0] cnt;
  logic [s_line-1:0] wline;
  logic busy_beat;
  assign busy_beat = (state == RD || state == WR) && resp_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = write_i ? WR : read_i ? RD : IDLE;
      RD, WR:  state_n = (resp_i && cnt == last_beat) ? DONE : state;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    resp_o  = state == DONE;
    burst_o = wline[s_burst*cnt +: s_burst];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt       <= '0;
      wline     <= '0;
      line_o    <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
    end else begin
      if (state == IDLE && (write_i || read_i)) begin
        address_o <= address_i & ~off_mask;
        write_o   <= write_i;
        read_o    <= !write_i;
        if (write_i) wline <= line_i;
      end
      if (state == RD && resp_i) line_o[s_burst*cnt +: s_burst] <= burst_i;
      if (busy_beat) begin
        cnt <= cnt + 2'd1;
        if (cnt == last_beat) begin
          read_o  <= 1'b0;
          write_o <= 1'b0;
        end
      end
      if (state == DONE) cnt <= '0;
    end
`ifdef CACHELINE_ADAPTOR_PERF_EN
  logic is_wr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      is_wr      <= 1'b0;
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else begin
      if (state == IDLE && (write_i || read_i)) is_wr <= write_i;
      if (state == DONE && is_wr)  wr_count_o <= wr_count_o + 32'd1;
      if (state == DONE && !is_wr) rd_count_o <= rd_count_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed vector table plus hand sequences for the cacheline_adaptor burst converter.
module tb_cacheline_adaptor;
  logic clk = 0, rst = 1;
  logic [255:0] line_i = '0, line_o;
  logic [31:0] address_i = '0, address_o;
  logic read_i = 0, write_i = 0, resp_o, read_o, write_o, resp_i = 0;
  logic [63:0] burst_i = '0, burst_o;
`ifdef CACHELINE_ADAPTOR_PERF_EN
  logic [31:0] rd_count_o, wr_count_o;
`endif
  int tests = 0, fails = 0;
  cacheline_adaptor dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o), .address_i(address_i),
    .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
`ifdef CACHELINE_ADAPTOR_PERF_EN
    , .rd_count_o(rd_count_o), .wr_count_o(wr_count_o)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rd, rs;
    logic [31:0] ad;
    logic [63:0] bu;
    logic e_rd, e_wr, e_resp;
    logic [31:0] e_ad;
  } vec_t;
  vec_t tv[7];
  task automatic tick;
    @(posedge clk); #1;
  endtask
  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic read_line(input logic [31:0] a, input logic [255:0] d, input string n);
    read_i = 1; address_i = a; resp_i = 0; tick;
    chk({n, " read_o"}, read_o, 1);
    chk({n, " address_o"}, address_o, a & ~32'h1f);
    for (int k = 0; k < 4; k++) begin
      resp_i = 1; burst_i = d[64*k +: 64]; tick;
    end
    chk({n, " resp_o"}, resp_o, 1);
    chk({n, " read_o done"}, read_o, 0);
    chk({n, " line_o"}, line_o, d);
    read_i = 0; resp_i = 0; tick;
    chk({n, " resp_o clr"}, resp_o, 0);
  endtask
  task automatic write_line(input logic [31:0] a, input logic [255:0] d, input string n);
    write_i = 1; address_i = a; line_i = d; resp_i = 0; tick;
    chk({n, " write_o"}, write_o, 1);
    chk({n, " read_o"}, read_o, 0);
    for (int k = 0; k < 4; k++) begin
      chk({n, " burst_o"}, burst_o, d[64*k +: 64]);
      resp_i = 1; tick;
    end
    chk({n, " resp_o"}, resp_o, 1);
    chk({n, " write_o done"}, write_o, 0);
    write_i = 0; resp_i = 0;
  endtask
  initial begin #200000; $display("FAIL watchdog expired"); $fatal(1); end
  initial begin
    logic [255:0] wl, saved;
    int beats, pulses;
    tv[0] = '{1, 0, 32'h1234, 64'h0,                  1, 0, 0, 32'h1220};
    tv[1] = '{1, 1, 32'h1234, 64'h1111111111111111,   1, 0, 0, 32'h1220};
    tv[2] = '{1, 1, 32'h1234, 64'h2222222222222222,   1, 0, 0, 32'h1220};
    tv[3] = '{1, 1, 32'h1234, 64'h3333333333333333,   1, 0, 0, 32'h1220};
    tv[4] = '{1, 1, 32'h1234, 64'h4444444444444444,   0, 0, 1, 32'h1220};
    tv[5] = '{0, 0, 32'h1234, 64'h0,                  0, 0, 0, 32'h1220};
    tv[6] = '{0, 1, 32'h1234, 64'h5555555555555555,   0, 0, 0, 32'h1220};
    tick; tick;
    chk("reset line_o", line_o, 0);
    chk("reset address_o", address_o, 0);
    chk("reset burst_o", burst_o, 0);
    chk("reset ctl", {read_o, write_o, resp_o}, 0);
    rst = 0; tick;
    for (int i = 0; i < 7; i++) begin
      read_i = tv[i].rd; resp_i = tv[i].rs; address_i = tv[i].ad; burst_i = tv[i].bu;
      tick;
      chk($sformatf("vec%0d read_o", i), read_o, tv[i].e_rd);
      chk($sformatf("vec%0d write_o", i), write_o, tv[i].e_wr);
      chk($sformatf("vec%0d resp_o", i), resp_o, tv[i].e_resp);
      chk($sformatf("vec%0d address_o", i), address_o, tv[i].e_ad);
    end
    resp_i = 0;
    chk("zw read line_o", line_o, {64'h4444444444444444, 64'h3333333333333333,
                                   64'h2222222222222222, 64'h1111111111111111});
    // write with stalls: beats accepted on cycles 2,5,6,9 after write_o rises
    wl = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
    write_i = 1; address_i = 32'h800000E0; line_i = wl; tick;
    chk("stall write_o", write_o, 1);
    chk("stall address_o", address_o, 32'h800000E0);
    beats = 0; pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      if (beats < 4) chk($sformatf("stall burst_o c%0d", c), burst_o, wl[64*beats +: 64]);
      resp_i = (c == 2 || c == 5 || c == 6 || c == 9);
      tick;
      if (resp_i && beats < 4) beats++;
      chk($sformatf("stall write_o c%0d", c), write_o, beats < 4);
      chk($sformatf("stall resp_o c%0d", c), resp_o, c == 9);
      if (resp_o) begin pulses++; write_i = 0; end
    end
    resp_i = 0;
    chk("stall resp pulses", pulses, 1);
    chk("stall line_o untouched", line_o, {64'h4444444444444444, 64'h3333333333333333,
                                           64'h2222222222222222, 64'h1111111111111111});
    // simultaneous read/write resolves as a write
    read_i = 1; write_i = 1; address_i = 32'h40; line_i = {4{64'hA5A5A5A5_5A5A5A5A}}; tick;
    chk("simul write_o", write_o, 1);
    chk("simul read_o", read_o, 0);
    for (int k = 0; k < 4; k++) begin resp_i = 1; tick; end
    chk("simul resp_o", resp_o, 1);
    read_i = 0; write_i = 0; resp_i = 0; tick;
    chk("simul idle", {read_o, write_o, resp_o}, 0);
    // reset asserted asynchronously after two beats of a read
    read_i = 1; address_i = 32'h2000; tick;
    resp_i = 1; burst_i = 64'hDEAD; tick; tick;
    #2 rst = 1; #1;
    chk("arst line_o", line_o, 0);
    chk("arst address_o", address_o, 0);
    chk("arst ctl", {read_o, write_o, resp_o}, 0);
    read_i = 0; resp_i = 0;
    @(negedge clk) rst = 0;
    tick;
    read_line(32'h3010, {64'hD4, 64'hC3, 64'hB2, 64'hA1}, "post-rst read");
    // back-to-back writeback then read, from a fresh reset
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    tick;
    write_line(32'h4000, {64'h4, 64'h3, 64'h2, 64'h1}, "b2b write");
    read_i = 1; address_i = 32'h5000; tick;
    chk("b2b gap ctl", {read_o, write_o, resp_o}, 0);
    read_line(32'h5000, {64'h8, 64'h7, 64'h6, 64'h5}, "b2b read");
    tick;
    chk("b2b no extra", {read_o, write_o, resp_o}, 0);
`ifdef CACHELINE_ADAPTOR_PERF_EN
    chk("b2b rd_count", rd_count_o, 1);
    chk("b2b wr_count", wr_count_o, 1);
`endif
    // stray resp_i in IDLE
    saved = line_o;
    resp_i = 1; burst_i = 64'hBAD0BAD0BAD0BAD0; tick;
    chk("stray line_o", line_o, saved);
    chk("stray ctl", {read_o, write_o, resp_o}, 0);
    resp_i = 0; tick;
    chk("stray still idle", {read_o, write_o, resp_o}, 0);
`ifdef CACHELINE_ADAPTOR_PERF_EN
    chk("stray rd_count", rd_count_o, 1);
    chk("stray wr_count", wr_count_o, 1);
`endif
    read_line(32'h6000, {64'hF4, 64'hF3, 64'hF2, 64'hF1}, "after stray read");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
